au_div_4b: RTL and testbench

Sequential 4-bit unsigned restoring divider that uses the subtract path of the arithmetic unit once per cycle. Given dividend A and divisor B, it produces quotient Q and remainder R after four iterations, using a start/busy/done handshake. It sits beside the 4-bit add/subtract unit in the datapath and covers the division direction, which the combinational unit cannot provide.

---
 rtl/au_div_4b.sv | 113 +++++++++++
 tb/tb_au_div_4b.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_div_4b.sv
// Sequential 4-bit unsigned restoring divider: one trial subtraction per cycle,
// four iterations, start/busy/done handshake with registered Q, R and DZ.
module au_div_4b (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       busy,
  output logic       done,
  output logic [3:0] Q,
  output logic [3:0] R,
  output logic       DZ
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state_q;
  logic [4:0] rem_q;
  logic [3:0] quo_q;
  logic [3:0] div_q;
  logic [1:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic [3:0] q_q;
  logic [3:0] r_q;
  logic       dz_q;

  logic [4:0] sh_d;
  logic [4:0] t_d;
  logic [4:0] rem_d;
  logic [3:0] quo_d;

  // rem stays below div, so bit 4 of the 5-bit difference is a clean borrow flag.
  always_comb begin
    sh_d = {rem_q[3:0], quo_q[3]};
    t_d  = sh_d - {1'b0, div_q};
    if (!t_d[4]) begin
      rem_d = t_d;
      quo_d = {quo_q[2:0], 1'b1};
    end else begin
      rem_d = sh_d;
      quo_d = {quo_q[2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (B != 4'd0) begin
              quo_q   <= A;
              div_q   <= B;
              rem_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end else begin
              q_q     <= 4'hF;
              r_q     <= A;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 2'd1;
          // Result registers load on the final iteration so they are valid with done.
          if (cnt_q == 2'd3) begin
            q_q     <= quo_d;
            r_q     <= rem_d[3:0];
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Q    = q_q;
  assign R    = r_q;
  assign DZ   = dz_q;

endmodule

// File: tb/tb_au_div_4b.sv
// Directed and exhaustive checks of au_div_4b: handshake timing, results,
// divide-by-zero, ignored start while busy, and mid-operation reset.
module tb_au_div_4b;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [3:0] Q;
  logic [3:0] R;
  logic       DZ;

  int errors = 0;
  int checks = 0;

  au_div_4b dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .Q    (Q),
    .R    (R),
    .DZ   (DZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise start for one cycle; the edge it spans is the accepting edge when idle.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count cycles after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int lat, output int nbusy, output bit both);
    lat = -1;
    nbusy = 0;
    both = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (busy && done) both = 1'b1;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) nbusy++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    A = 4'd5;
    B = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, Q, R, DZ} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b Q=%0d R=%0d DZ=%b, required all zero",
               busy, done, Q, R, DZ);
    end
    $display("reset: busy=%b done=%b Q=%0d R=%0d DZ=%b", busy, done, Q, R, DZ);
    reset = 1'b0;
    start = 1'b0;
    next_cycle();
  endtask

  task automatic test_basic();
    int lat, nb;
    bit both;
    start_op(4'd13, 4'd4);
    wait_done(lat, nb, both);
    $display("basic 13/4: lat=%0d busy_cycles=%0d Q=%0d R=%0d DZ=%b", lat, nb, Q, R, DZ);
    checks++;
    if (lat !== 4 || nb !== 4) begin
      errors++;
      $display("FAIL basic_timing: lat=%0d busy_cycles=%0d, required lat=4 busy_cycles=4", lat, nb);
    end
    checks++;
    if (Q !== 4'd3 || R !== 4'd1 || DZ !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: Q=%0d R=%0d DZ=%b, required Q=3 R=1 DZ=0", Q, R, DZ);
    end
    checks++;
    if (both) begin
      errors++;
      $display("FAIL basic_busy_done_overlap: both=1, required 0");
    end
    next_cycle();
    checks++;
    if (done !== 1'b0 || Q !== 4'd3 || R !== 4'd1) begin
      errors++;
      $display("FAIL basic_pulse_hold: done=%b Q=%0d R=%0d, required done=0 Q=3 R=1", done, Q, R);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    bit both;
    start_op(4'd15, 4'd1);
    wait_done(lat, nb, both);
    $display("b2b 15/1: lat=%0d Q=%0d R=%0d", lat, Q, R);
    checks++;
    if (lat !== 4 || Q !== 4'd15 || R !== 4'd0 || DZ !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d Q=%0d R=%0d DZ=%b, required lat=4 Q=15 R=0 DZ=0", lat, Q, R, DZ);
    end
    next_cycle();
    start_op(4'd3, 4'd9);
    wait_done(lat, nb, both);
    $display("b2b 3/9: lat=%0d Q=%0d R=%0d", lat, Q, R);
    checks++;
    if (lat !== 4 || Q !== 4'd0 || R !== 4'd3 || DZ !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d Q=%0d R=%0d DZ=%b, required lat=4 Q=0 R=3 DZ=0", lat, Q, R, DZ);
    end
    next_cycle();
  endtask

  task automatic test_div_zero();
    int lat, nb;
    bit both;
    start_op(4'd7, 4'd0);
    wait_done(lat, nb, both);
    $display("dz 7/0: lat=%0d busy_cycles=%0d Q=%0d R=%0d DZ=%b", lat, nb, Q, R, DZ);
    checks++;
    if (lat !== 0 || nb !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dz_timing: lat=%0d busy_cycles=%0d busy=%b, required lat=0 busy_cycles=0 busy=0", lat, nb, busy);
    end
    checks++;
    if (Q !== 4'hF || R !== 4'd7 || DZ !== 1'b1) begin
      errors++;
      $display("FAIL dz_result: Q=%0d R=%0d DZ=%b, required Q=15 R=7 DZ=1", Q, R, DZ);
    end
    next_cycle();
    start_op(4'd8, 4'd2);
    wait_done(lat, nb, both);
    $display("after dz 8/2: lat=%0d Q=%0d R=%0d DZ=%b", lat, Q, R, DZ);
    checks++;
    if (lat !== 4 || Q !== 4'd4 || R !== 4'd0 || DZ !== 1'b0) begin
      errors++;
      $display("FAIL dz_recover: lat=%0d Q=%0d R=%0d DZ=%b, required lat=4 Q=4 R=0 DZ=0", lat, Q, R, DZ);
    end
    next_cycle();
  endtask

  task automatic test_ignore_start();
    int lat, nb, pulses;
    bit both;
    start_op(4'd13, 4'd4);
    A = 4'd9;
    B = 4'd2;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    wait_done(lat, nb, both);
    $display("ignore 13/4: lat=%0d Q=%0d R=%0d", lat + 1, Q, R);
    checks++;
    if (lat !== 3 || Q !== 4'd3 || R !== 4'd1 || DZ !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: lat=%0d Q=%0d R=%0d DZ=%b, required lat=4 Q=3 R=1 DZ=0", lat + 1, Q, R, DZ);
    end
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      next_cycle();
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL ignore_extra_activity: cycles=%0d, required 0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nb, pulses;
    bit both;
    start_op(4'd13, 4'd4);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    $display("mid reset: busy=%b done=%b Q=%0d R=%0d", busy, done, Q, R);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Q !== 4'd0 || R !== 4'd0 || DZ !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: busy=%b done=%b Q=%0d R=%0d DZ=%b, required all zero", busy, done, Q, R, DZ);
    end
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      if (done || busy) pulses++;
      next_cycle();
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL midreset_no_done: cycles=%0d, required 0", pulses);
    end
    start_op(4'd10, 4'd3);
    wait_done(lat, nb, both);
    $display("after reset 10/3: lat=%0d Q=%0d R=%0d", lat, Q, R);
    checks++;
    if (lat !== 4 || Q !== 4'd3 || R !== 4'd1 || DZ !== 1'b0) begin
      errors++;
      $display("FAIL midreset_recover: lat=%0d Q=%0d R=%0d DZ=%b, required lat=4 Q=3 R=1 DZ=0", lat, Q, R, DZ);
    end
    next_cycle();
  endtask

  task automatic test_sweep();
    int lat, nb, eq, er, elat;
    bit both, edz, ok;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_op(a[3:0], b[3:0]);
        wait_done(lat, nb, both);
        if (b == 0) begin
          eq = 15; er = a; edz = 1'b1; elat = 0;
        end else begin
          eq = a / b; er = a % b; edz = 1'b0; elat = 4;
        end
        ok = (lat == elat) && (int'(Q) == eq) && (int'(R) == er) && (DZ === edz) && !both;
        if (b != 0) ok = ok && (a == int'(Q) * b + int'(R)) && (int'(R) < b);
        $display("sweep %0d/%0d: lat=%0d Q=%0d R=%0d DZ=%b", a, b, lat, Q, R, DZ);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL sweep_%0d_%0d: lat=%0d Q=%0d R=%0d DZ=%b overlap=%b, required lat=%0d Q=%0d R=%0d DZ=%b",
                   a, b, lat, Q, R, DZ, both, elat, eq, er, edz);
        end
        next_cycle();
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    A = 4'd0;
    B = 4'd0;
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
